// File: rtl/bus_pkg.sv
// Shared definitions for the physical-address bus responder: FSM states,
// decode targets, MMIO register offsets and a byte-merge helper.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TGT_RAM  = 2'd0,
    TGT_MMIO = 2'd1,
    TGT_ERR  = 2'd2
  } target_t;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1FAF_0000;

  localparam logic [15:0] MMIO_LED     = 16'h0000;
  localparam logic [15:0] MMIO_SWITCH  = 16'h0004;
  localparam logic [15:0] MMIO_COUNTER = 16'h0008;
  localparam logic [15:0] MMIO_SCRATCH = 16'h000C;

  // Replace the byte lanes of old_val selected by strb with new_val's lanes.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bram_byte_we.sv
// Single-port synchronous RAM with per-byte write enables. Read data is
// registered and only updates on an enabled cycle, so it holds steady while
// the port is idle. Contents are deliberately never cleared.
module bram_byte_we #(
  parameter int WORDS = 4096,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Byte-masked write and read-before-write capture on each enabled cycle.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/phys_bus_responder.sv
// Target end of the physical-address bus: accepts one request at a time,
// decodes it to on-chip RAM, the MMIO bank or an error, and returns the
// result over a valid/ready response channel.
module phys_bus_responder
  import bus_pkg::*;
#(
  parameter int          RAM_WORDS = 4096,
  parameter int          RAM_WAIT  = 2,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;
  localparam logic [15:0] WAIT_INIT = 16'((RAM_WAIT > 0) ? RAM_WAIT - 1 : 0);

  state_t        state;
  target_t       req_tgt;
  target_t       lat_tgt;
  logic          lat_write;
  logic [AW-1:0] lat_word;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_wstrb;
  logic [15:0]   wait_cnt;
  logic [31:0]   rdata_reg;
  logic [15:0]   led;
  logic [31:0]   scratch;
  logic [31:0]   counter;
  logic [31:0]   mmio_rdata;

  logic          accept;
  logic          ram_go;
  logic          ram_from_req;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [3:0]    ram_we;
  logic [31:0]   ram_rdata;

  assign accept = (state == ST_IDLE) && req_valid;

  // Decode the incoming address; misalignment takes priority over any region.
  always_comb begin
    req_tgt = TGT_ERR;
    if (req_addr[1:0] != 2'b00) begin
      req_tgt = TGT_ERR;
    end else if ({1'b0, req_addr} < RAM_BYTES) begin
      req_tgt = TGT_RAM;
    end else if (req_addr[31:16] == MMIO_BASE[31:16]) begin
      case (req_addr[15:0])
        MMIO_LED, MMIO_SWITCH, MMIO_COUNTER, MMIO_SCRATCH: req_tgt = TGT_MMIO;
        default:                                          req_tgt = TGT_ERR;
      endcase
    end
  end

  // MMIO read mux; the switch value is therefore sampled in the request cycle.
  always_comb begin
    mmio_rdata = 32'h0;
    case (req_addr[15:0])
      MMIO_LED:     mmio_rdata = {16'h0, led};
      MMIO_SWITCH:  mmio_rdata = {16'h0, sw_in};
      MMIO_COUNTER: mmio_rdata = counter;
      MMIO_SCRATCH: mmio_rdata = scratch;
      default:      mmio_rdata = 32'h0;
    endcase
  end

  // RAM is touched exactly once, on the edge that enters RESP. Zero-wait
  // accesses use the live request; waited ones use the latched copy.
  assign ram_go = rst && ((accept && (req_tgt == TGT_RAM) && (RAM_WAIT == 0)) ||
                          ((state == ST_WAIT) && (wait_cnt == 16'h0)));
  assign ram_from_req = (state == ST_IDLE);
  assign ram_addr     = ram_from_req ? req_addr[AW+1:2] : lat_word;
  assign ram_wdata    = ram_from_req ? req_wdata : lat_wdata;
  assign ram_we       = (ram_go && (ram_from_req ? req_write : lat_write)) ?
                        (ram_from_req ? req_wstrb : lat_wstrb) : 4'b0000;

  bram_byte_we #(
    .WORDS(RAM_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .en   (ram_go),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // Request FSM plus MMIO side effects, which land on the acceptance edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      lat_tgt   <= TGT_ERR;
      lat_write <= 1'b0;
      lat_word  <= '0;
      lat_wdata <= 32'h0;
      lat_wstrb <= 4'h0;
      wait_cnt  <= 16'h0;
      rdata_reg <= 32'h0;
      led       <= 16'h0;
      scratch   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_tgt   <= req_tgt;
            lat_write <= req_write;
            lat_word  <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
            rdata_reg <= (req_tgt == TGT_MMIO && !req_write) ? mmio_rdata : 32'h0;
            if (req_tgt == TGT_MMIO && req_write) begin
              if (req_addr[15:0] == MMIO_LED) begin
                if (req_wstrb[0]) led[7:0]  <= req_wdata[7:0];
                if (req_wstrb[1]) led[15:8] <= req_wdata[15:8];
              end
              if (req_addr[15:0] == MMIO_SCRATCH) begin
                scratch <= merge_bytes(scratch, req_wdata, req_wstrb);
              end
            end
            if (req_tgt == TGT_RAM && RAM_WAIT > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_INIT;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 16'h0) state <= ST_RESP;
          else                   wait_cnt <= wait_cnt - 16'h1;
        end
        ST_RESP: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Free-running cycle counter exposed through MMIO.
  always_ff @(posedge clk) begin
    if (!rst) counter <= 32'h0;
    else      counter <= counter + 32'h1;
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && (lat_tgt == TGT_ERR);
  assign resp_rdata = (state != ST_RESP)                    ? 32'h0 :
                      (lat_tgt == TGT_RAM && !lat_write)     ? ram_rdata :
                                                               rdata_reg;
  assign led_out    = led;

endmodule

// File: doc/phys_bus_responder.md
Name: phys_bus_responder

Overview:
- Target-side end of the CPU physical-address bus: accepts one translated read or write request at a time and services it.
- Decodes the physical address into on-chip RAM, a small MMIO register bank, or an error region.
- Returns read data or write completion through a valid/ready response channel.
- Sits downstream of the fixed-mapping address translator; serves as the FPGA/simulation memory and peripheral target.

Parameters:
- RAM_WORDS, 4096, on-chip RAM depth in 32-bit words; must be a power of two.
- RAM_WAIT, 2, extra wait cycles for RAM accesses; 0 is legal.
- MMIO_BASE, 32'h1FAF_0000, base physical address of the MMIO bank (64 KiB window).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  physical byte address
- req_wdata  in  32  write data
- req_wstrb  in  4  byte enables, bit i enables byte lane i
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts the response
- resp_rdata  out  32  read data; 0 for writes and for errors
- resp_err  out  1  decode or alignment error
- sw_in  in  16  board switch inputs
- led_out  out  16  LED register value

Behaviour:
- Reset (rst==0 at a clock edge):
  - state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0.
  - led_out=0; SCRATCH=0; COUNTER=0; wait counter=0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch addr, write, wdata and wstrb; decode; req_ready drops on the next cycle.
  - Next state: RAM hit with RAM_WAIT>0 goes to WAIT with counter=RAM_WAIT-1; every other case goes to RESP.
  - The first response is therefore visible 1 cycle after acceptance for MMIO, error and zero-wait RAM, and 1+RAM_WAIT cycles after acceptance for waited RAM.
- WAIT: counter decrements each cycle; go to RESP when counter==0.
- RESP:
  - resp_valid=1; resp_rdata and resp_err stay stable until resp_ready=1.
  - On the handshake cycle, go to IDLE; resp_valid=0 on the next cycle.
  - Back-to-back throughput is at most one request per 2 cycles.
- Decode (on latched addr):
  - addr[1:0]!=0 → err.
  - addr < RAM_WORDS*4 → RAM; word index = addr[log2(RAM_WORDS)+1:2].
  - addr[31:16]==MMIO_BASE[31:16] → MMIO, using offset addr[15:0].
  - Anything else → err.
- MMIO map:
  - 0x00 LED: rw, 16 bits in [15:0]; upper bits read 0.
  - 0x04 SWITCH: ro, {16'b0, sw_in}; sampled in the request cycle.
  - 0x08 COUNTER: ro, free-running 32-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF→0.
  - 0x0C SCRATCH: rw, 32 bits.
  - A write to a ro register is ignored with err=0.
  - Any other offset → err.
- Write side effects:
  - Applied exactly once, at the transition into RESP.
  - Per-byte per wstrb; wstrb==0 is a legal no-op.
  - Errors never modify state.
- RAM read data is sampled at the transition into RESP.
- Requests arriving while req_ready=0 are not accepted; the requester must hold them.
- Reset asserted mid-transaction aborts it with no response.
  - A pending write that has not yet reached RESP is discarded.

Decomposition:
- Shared package bus_pkg:
  - FSM state enum.
  - MMIO offset constants LED/SWITCH/COUNTER/SCRATCH.
  - MMIO_BASE default.
  - Decode-target enum RAM/MMIO/ERR.
- One sub-module, bram_byte_we: single-port synchronous RAM with 4 byte-write enables and RAM_WORDS depth, instantiated once.
- FSM, decode and MMIO logic live in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 with wstrb=4'hF, then read 0x10 → rdata=0xDEADBEEF, err=0. With RAM_WAIT=2, resp_valid rises exactly 3 cycles after each acceptance.
- Byte-write 0x0000_00AA to 0x10 with wstrb=4'b0001, then read → 0xDEADBEAA.
- Write 0x1234 to 0x1FAF_0000 → led_out=0x1234 on the cycle after acceptance. Read 0x1FAF_0004 with sw_in=0x00F0 → 0x0000_00F0. Two COUNTER reads 10 cycles apart differ by 10.
- Read 0x0000_0012 (misaligned), read 0x2000_0000 (unmapped) and write 0x1FAF_0010 → each returns err=1, rdata=0; a following SCRATCH read still returns its prior value.
- Hold resp_ready=0 for 5 cycles on a read → resp_valid and rdata stay stable and req_ready stays 0. After the handshake, a new request is accepted in the next IDLE cycle.
- Assert rst during WAIT of a write to 0x20 → resp_valid=0 and FSM in IDLE after reset; reading 0x20 returns the old content; led_out=0.
